// File: rtl/bus_slave_mux_reg_pkg.sv
// Shared polarities, state encoding and defaults for the registered bus slave read-return mux.
package bus_slave_mux_reg_pkg;

  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;

  localparam int unsigned DEF_NUM_SLAVES = 8;
  localparam int unsigned DEF_DATA_W     = 32;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  // Bits needed to encode n distinct values, never less than one.
  function automatic int unsigned width_of(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bus_slave_mux_wdt.sv
// Saturating transfer watchdog; expire_c flags the last permitted wait cycle.
module bus_slave_mux_wdt
  import bus_slave_mux_reg_pkg::*;
#(
  parameter  int unsigned TIMEOUT = 255,
  localparam int unsigned CNT_W   = width_of(TIMEOUT + 1)
) (
  input  logic clk,
  input  logic reset_,
  input  logic clr,
  input  logic en,
  output logic expire_c
);

  localparam logic WDT_ON = (TIMEOUT != 0);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // A zero TIMEOUT disables expiry entirely.
  assign expire_c = WDT_ON && (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/bus_slave_mux_reg.sv
// Registered slave read-return multiplexer: latches the selected slave at transfer start,
// returns its data/ready one cycle later and ends hung transfers with a bus error.
module bus_slave_mux_reg
  import bus_slave_mux_reg_pkg::*;
#(
  parameter  int unsigned NUM_SLAVES = DEF_NUM_SLAVES,
  parameter  int unsigned DATA_W     = DEF_DATA_W,
  parameter  int unsigned TIMEOUT    = 255,
  localparam int unsigned IDX_W      = width_of(NUM_SLAVES)
) (
  input  logic                         clk,
  input  logic                         reset_,
  input  logic                         m_as_,
  input  logic [NUM_SLAVES-1:0]        s_cs_,
  input  logic [NUM_SLAVES*DATA_W-1:0] s_rd_data,
  input  logic [NUM_SLAVES-1:0]        s_rdy_,
  output logic [DATA_W-1:0]            m_rd_data,
  output logic                         m_rdy_,
  output logic                         m_err_,
  output logic [IDX_W-1:0]             err_idx,
  output logic                         busy
);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   sel_q, sel_d;
  logic [DATA_W-1:0]  rd_data_d;
  logic               rdy_d, err_d, busy_d;
  logic [IDX_W-1:0]   err_idx_d;

  logic               any_cs;
  logic [IDX_W-1:0]   cs_idx;
  logic [DATA_W-1:0]  cs_data, sel_data;
  logic               cs_rdy_, sel_rdy_;
  logic               expire_c;

  // Lowest-index asserted chip select wins.
  always_comb begin
    any_cs = 1'b0;
    cs_idx = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (!s_cs_[i] && !any_cs) begin
        any_cs = 1'b1;
        cs_idx = IDX_W'(i);
      end
    end
  end

  // Return-path views of the newly decoded slave and of the latched one.
  always_comb begin
    cs_data  = '0;
    cs_rdy_  = DISABLE_;
    sel_data = '0;
    sel_rdy_ = DISABLE_;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (IDX_W'(i) == cs_idx) begin
        cs_data = s_rd_data[i*DATA_W +: DATA_W];
        cs_rdy_ = s_rdy_[i];
      end
      if (IDX_W'(i) == sel_q) begin
        sel_data = s_rd_data[i*DATA_W +: DATA_W];
        sel_rdy_ = s_rdy_[i];
      end
    end
  end

  bus_slave_mux_wdt #(
    .TIMEOUT (TIMEOUT)
  ) u_wdt (
    .clk      (clk),
    .reset_   (reset_),
    .clr      (state_q == IDLE),
    .en       ((state_q == WAIT) && sel_rdy_),
    .expire_c (expire_c)
  );

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    rd_data_d = m_rd_data;
    rdy_d     = DISABLE_;
    err_d     = DISABLE_;
    err_idx_d = err_idx;
    unique case (state_q)
      IDLE: begin
        if (!m_as_) begin
          if (any_cs) begin
            sel_d = cs_idx;
            if (!cs_rdy_) begin
              rd_data_d = cs_data;
              rdy_d     = ENABLE_;
            end else begin
              state_d = WAIT;
            end
          end else begin
            rd_data_d = '0;
            rdy_d     = ENABLE_;
            err_d     = ENABLE_;
          end
        end
      end
      WAIT: begin
        // Ready beats an expiry landing in the same cycle.
        if (!sel_rdy_) begin
          rd_data_d = sel_data;
          rdy_d     = ENABLE_;
          state_d   = IDLE;
        end else if (expire_c) begin
          rd_data_d = '0;
          rdy_d     = ENABLE_;
          err_d     = ENABLE_;
          err_idx_d = sel_q;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == WAIT);
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_q   <= IDLE;
      sel_q     <= '0;
      m_rd_data <= '0;
      m_rdy_    <= DISABLE_;
      m_err_    <= DISABLE_;
      err_idx   <= '0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      m_rd_data <= rd_data_d;
      m_rdy_    <= rdy_d;
      m_err_    <= err_d;
      err_idx   <= err_idx_d;
      busy      <= busy_d;
    end
  end

endmodule

// File: tb/tb_bus_slave_mux_reg.sv
// Scoreboard bench for bus_slave_mux_reg with an 8-slave, 32-bit, TIMEOUT=4 instance.
module tb_bus_slave_mux_reg;

  localparam int unsigned NS = 8;
  localparam int unsigned DW = 32;
  localparam int unsigned IW = 3;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          err_;
    logic [IW-1:0] idx;
  } exp_t;

  logic             clk;
  logic             reset_;
  logic             m_as_;
  logic [NS-1:0]    s_cs_;
  logic [NS*DW-1:0] s_rd_data;
  logic [NS-1:0]    s_rdy_;
  logic [DW-1:0]    m_rd_data;
  logic             m_rdy_;
  logic             m_err_;
  logic [IW-1:0]    err_idx;
  logic             busy;

  int   checks = 0;
  int   errors = 0;
  exp_t q[$];

  bus_slave_mux_reg #(
    .NUM_SLAVES (NS),
    .DATA_W     (DW),
    .TIMEOUT    (4)
  ) dut (
    .clk       (clk),
    .reset_    (reset_),
    .m_as_     (m_as_),
    .s_cs_     (s_cs_),
    .s_rd_data (s_rd_data),
    .s_rdy_    (s_rdy_),
    .m_rd_data (m_rd_data),
    .m_rdy_    (m_rdy_),
    .m_err_    (m_err_),
    .err_idx   (err_idx),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [DW-1:0] d, input logic e, input logic [IW-1:0] i);
    exp_t x;
    x.data = d;
    x.err_ = e;
    x.idx  = i;
    q.push_back(x);
  endtask

  task automatic idle_inputs();
    m_as_  = 1'b1;
    s_cs_  = '1;
    s_rdy_ = '1;
  endtask

  // Monitor: every master ready pulse must match the oldest expected response.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (reset_ === 1'b1 && m_rdy_ === 1'b0) begin
      if (q.size() == 0) begin
        check("unexpected_rdy", 32'(m_rdy_), 32'd1);
      end else begin
        e = q.pop_front();
        check("rd_data", m_rd_data, e.data);
        check("err_", 32'(m_err_), 32'(e.err_));
        check("err_idx", 32'(err_idx), 32'(e.idx));
      end
    end else if (reset_ === 1'b1 && m_err_ === 1'b0) begin
      check("err_without_rdy", 32'(m_err_), 32'd1);
    end
  end

  initial begin : guard
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    reset_ = 1'b0;
    idle_inputs();
    for (int i = 0; i < NS; i++) s_rd_data[i*DW +: DW] = 32'h1000_0000 + 32'(i);
    s_rd_data[2*DW +: DW] = 32'hDEAD_BEEF;
    s_rd_data[5*DW +: DW] = 32'hC0DE_0005;
    tick();
    tick();
    check("rst_rd_data", m_rd_data, 32'h0);
    check("rst_rdy_", 32'(m_rdy_), 32'd1);
    check("rst_err_", 32'(m_err_), 32'd1);
    check("rst_err_idx", 32'(err_idx), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    reset_ = 1'b1;
    tick();

    // Zero-wait read from slave 2.
    m_as_ = 1'b0; s_cs_[2] = 1'b0; s_rdy_[2] = 1'b0;
    push(32'hDEAD_BEEF, 1'b1, 3'd0);
    tick();
    idle_inputs();
    check("zw_busy", 32'(busy), 32'd0);
    tick();

    // Wait-state read from slave 5 with stray chip select / strobe during WAIT.
    m_as_ = 1'b0; s_cs_[5] = 1'b0;
    tick();
    check("ws_busy1", 32'(busy), 32'd1);
    s_cs_ = 8'b1111_1110; m_as_ = 1'b0;
    tick();
    check("ws_busy2", 32'(busy), 32'd1);
    idle_inputs();
    tick();
    check("ws_busy3", 32'(busy), 32'd1);
    s_rdy_[5] = 1'b0;
    push(32'hC0DE_0005, 1'b1, 3'd0);
    tick();
    idle_inputs();
    check("ws_busy_done", 32'(busy), 32'd0);
    tick();

    // Priority: slaves 1 and 6 selected together, only slave 6 ready at first.
    m_as_ = 1'b0; s_cs_ = 8'b1011_1101; s_rdy_[6] = 1'b0;
    tick();
    m_as_ = 1'b1;
    check("pri_busy", 32'(busy), 32'd1);
    tick();
    s_rdy_[1] = 1'b0;
    push(32'h1000_0001, 1'b1, 3'd0);
    tick();
    idle_inputs();
    tick();

    // Timeout on slave 3: four WAIT cycles then error.
    m_as_ = 1'b0; s_cs_[3] = 1'b0;
    tick();
    idle_inputs();
    push(32'h0, 1'b0, 3'd3);
    for (int c = 1; c <= 3; c++) begin
      tick();
      check("to_busy", 32'(busy), 32'd1);
    end
    tick();
    check("to_busy_done", 32'(busy), 32'd0);
    tick();

    // Ready on the fourth WAIT cycle wins over expiry.
    m_as_ = 1'b0; s_cs_[3] = 1'b0;
    tick();
    idle_inputs();
    tick();
    tick();
    tick();
    s_rdy_[3] = 1'b0;
    push(32'h1000_0003, 1'b1, 3'd3);
    tick();
    idle_inputs();
    check("race_busy", 32'(busy), 32'd0);
    tick();

    // Decode error: strobe with no chip select keeps err_idx.
    m_as_ = 1'b0;
    push(32'h0, 1'b0, 3'd3);
    tick();
    idle_inputs();
    tick();

    // Asynchronous reset in the middle of a WAIT.
    m_as_ = 1'b0; s_cs_[4] = 1'b0;
    tick();
    idle_inputs();
    tick();
    check("pre_rst_busy", 32'(busy), 32'd1);
    #2 reset_ = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_rdy_", 32'(m_rdy_), 32'd1);
    check("arst_err_idx", 32'(err_idx), 32'd0);
    tick();
    reset_ = 1'b1;
    tick();

    // Fresh read from slave 0 after reset.
    m_as_ = 1'b0; s_cs_[0] = 1'b0; s_rdy_[0] = 1'b0;
    push(32'h1000_0000, 1'b1, 3'd0);
    tick();
    idle_inputs();
    repeat (3) tick();

    check("queue_drained", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
